// File: rtl/pipelining_pkg.sv
// Shared types for the pipeline skid register: FSM state encoding, counter width
// and the occupancy next-state function.
package pipelining_pkg;

    localparam int PIPE_STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_skid_state_e;

    // Occupancy step: main is the head entry, skid catches the beat that arrives
    // while the registered ready is still high but downstream has stopped.
    function automatic pipe_skid_state_e skid_next_state(
        input pipe_skid_state_e st,
        input logic             in_xfer,
        input logic             out_xfer
    );
        pipe_skid_state_e nxt;
        nxt = st;
        case (st)
            EMPTY: nxt = in_xfer ? BUSY : EMPTY;
            BUSY: begin
                if (in_xfer && !out_xfer)
                    nxt = FULL;
                else if (!in_xfer && out_xfer)
                    nxt = EMPTY;
                else
                    nxt = BUSY;
            end
            FULL:    nxt = out_xfer ? BUSY : FULL;
            default: nxt = EMPTY;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pipeline_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the optional stall
// statistics (PIPELINE_SKID_PERF_EN).
module pipeline_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Sticks at all-ones so a long stall never wraps back to a small value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != {WIDTH{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_skid_register.sv
// Two-entry skid register with a flopped upstream ready, flush and stall controls.
// Optional stall-cycle counter port enabled by macro PIPELINE_SKID_PERF_EN.
module pipeline_skid_register
    import pipelining_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        s_data_valid,
    output logic                        s_data_ready,
    input  logic [DATA_WIDTH-1:0]       s_data_data,
    output logic                        m_data_valid,
    input  logic                        m_data_ready,
    output logic [DATA_WIDTH-1:0]       m_data_data,
    input  logic                        s_ctrl_flush,
    input  logic                        s_ctrl_stall,
    output logic                        s_status_busy
`ifdef PIPELINE_SKID_PERF_EN
    ,
    output logic [PIPE_STALL_CNT_W-1:0] s_status_stall_cnt
`endif
);

    pipe_skid_state_e      state_q;
    pipe_skid_state_e      state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  ready_q;

    logic                  in_xfer;
    logic                  out_xfer;
    logic                  load_main;
    logic                  load_skid;
    logic                  move_skid;

    // Stall masks both handshakes, so no transfer can be seen on either side.
    assign s_data_ready  = ready_q && !s_ctrl_stall;
    assign m_data_valid  = (state_q != EMPTY) && !s_ctrl_stall;
    assign m_data_data   = main_q;
    assign s_status_busy = (state_q != EMPTY);

    assign in_xfer  = s_data_valid && s_data_ready;
    assign out_xfer = m_data_valid && m_data_ready;

    always_comb begin
        state_d   = skid_next_state(state_q, in_xfer, out_xfer);
        load_main = in_xfer && ((state_q == EMPTY) || ((state_q == BUSY) && out_xfer));
        load_skid = in_xfer && (state_q == BUSY) && !out_xfer;
        move_skid = out_xfer && (state_q == FULL);
    end

    // Ready comes up one edge after reset release; flush wins over stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else if (s_ctrl_flush) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else if (!s_ctrl_stall) begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
            if (load_main)
                main_q <= s_data_data;
            else if (move_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= s_data_data;
        end
    end

`ifdef PIPELINE_SKID_PERF_EN
    pipeline_sat_counter #(
        .WIDTH (PIPE_STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (s_ctrl_flush),
        .inc   (m_data_valid && !m_data_ready && !s_ctrl_stall),
        .count (s_status_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Directed bench for pipeline_skid_register with an occupancy/ordering model;
// exercises the stall counter when PIPELINE_SKID_PERF_EN is defined.
module tb_pipeline_skid_register;

    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          s_data_valid;
    logic          s_data_ready;
    logic [DW-1:0] s_data_data;
    logic          m_data_valid;
    logic          m_data_ready;
    logic [DW-1:0] m_data_data;
    logic          s_ctrl_flush;
    logic          s_ctrl_stall;
    logic          s_status_busy;
`ifdef PIPELINE_SKID_PERF_EN
    logic [15:0]   s_status_stall_cnt;
    int unsigned   model_cnt;
`endif

    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] model_q[$];
    logic          model_ready;
    int            checks = 0;
    int            errors = 0;

    always #5 clk_i = ~clk_i;

    pipeline_skid_register #(.DATA_WIDTH(DW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s_data_valid  (s_data_valid),
        .s_data_ready  (s_data_ready),
        .s_data_data   (s_data_data),
        .m_data_valid  (m_data_valid),
        .m_data_ready  (m_data_ready),
        .m_data_data   (m_data_data),
        .s_ctrl_flush  (s_ctrl_flush),
        .s_ctrl_stall  (s_ctrl_stall),
        .s_status_busy (s_status_busy)
`ifdef PIPELINE_SKID_PERF_EN
        ,
        .s_status_stall_cnt (s_status_stall_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic flush, input logic stall, input logic mready);
        s_ctrl_flush = flush;
        s_ctrl_stall = stall;
        m_data_ready = mready;
        s_data_valid = (tx_q.size() > 0);
        s_data_data  = (tx_q.size() > 0) ? tx_q[0] : '0;
    endtask

    // Scoreboard head is the entry the DUT must currently present downstream.
    task automatic checkOutput();
        check_val("s_data_ready", 64'(s_data_ready), 64'(model_ready && !s_ctrl_stall));
        check_val("m_data_valid", 64'(m_data_valid), 64'((model_q.size() > 0) && !s_ctrl_stall));
        check_val("s_status_busy", 64'(s_status_busy), 64'(model_q.size() > 0));
        if (model_q.size() > 0)
            check_val("m_data_data", 64'(m_data_data), 64'(model_q[0]));
`ifdef PIPELINE_SKID_PERF_EN
        check_val("stall_cnt", 64'(s_status_stall_cnt), 64'(model_cnt));
`endif
    endtask

    task automatic cycle(input logic flush, input logic stall, input logic mready);
        logic exp_ready;
        logic exp_valid;
        logic in_x;
        logic out_x;
        applyStimulus(flush, stall, mready);
        #1;
        checkOutput();
        exp_ready = model_ready && !stall;
        exp_valid = (model_q.size() > 0) && !stall;
        in_x      = s_data_valid && exp_ready;
        out_x     = exp_valid && mready;
        @(posedge clk_i);
        if (flush) begin
            if (s_data_valid)
                void'(tx_q.pop_front());
            model_q.delete();
            model_ready = 1'b1;
`ifdef PIPELINE_SKID_PERF_EN
            model_cnt = 0;
`endif
        end else if (!stall) begin
`ifdef PIPELINE_SKID_PERF_EN
            if (exp_valid && !mready && model_cnt < 32'hFFFF)
                model_cnt++;
`endif
            if (out_x)
                void'(model_q.pop_front());
            if (in_x)
                model_q.push_back(tx_q.pop_front());
            model_ready = (model_q.size() != 2);
        end
        @(negedge clk_i);
    endtask

    // Asynchronous reset in the middle of a low clock phase.
    task automatic do_reset();
        #2;
        rst_i = 1'b1;
        #1;
        model_q.delete();
        tx_q.delete();
        model_ready = 1'b0;
`ifdef PIPELINE_SKID_PERF_EN
        model_cnt = 0;
        check_val("rst_stall_cnt", 64'(s_status_stall_cnt), 64'h0);
`endif
        check_val("rst_ready", 64'(s_data_ready), 64'h0);
        check_val("rst_valid", 64'(m_data_valid), 64'h0);
        check_val("rst_data", 64'(m_data_data), 64'h0);
        check_val("rst_busy", 64'(s_status_busy), 64'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i        = 1'b0;
        s_data_valid = 1'b0;
        s_data_data  = '0;
        m_data_ready = 1'b0;
        s_ctrl_flush = 1'b0;
        s_ctrl_stall = 1'b0;
        model_ready  = 1'b0;
`ifdef PIPELINE_SKID_PERF_EN
        model_cnt    = 0;
`endif
        @(negedge clk_i);
        do_reset();

        // Ready appears one edge after release, A5 accepted next, shown a cycle later
        tx_q.push_back(32'hA5);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check_val("a5_latency_data", 64'(m_data_data), 64'hA5);
        check_val("a5_latency_valid", 64'(m_data_valid), 64'h1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);

        // Back-to-back stream at full rate
        for (int i = 1; i <= 8; i++)
            tx_q.push_back(DW'(i));
        repeat (11) cycle(0, 0, 1);

        // Downstream backpressure fills main and skid, third beat waits upstream
        tx_q.push_back(32'h10);
        tx_q.push_back(32'h11);
        tx_q.push_back(32'h12);
        repeat (4) cycle(0, 0, 0);
        check_val("bp_main", 64'(m_data_data), 64'h10);
        check_val("bp_ready", 64'(s_data_ready), 64'h0);
        check_val("bp_held", 64'(s_data_data), 64'h12);
        repeat (5) cycle(0, 0, 1);

        // Flush from FULL drops both entries and the offered 0x55
        tx_q.push_back(32'h20);
        tx_q.push_back(32'h21);
        repeat (3) cycle(0, 0, 0);
        tx_q.push_back(32'h55);
        cycle(1, 0, 0);
        check_val("flush_valid", 64'(m_data_valid), 64'h0);
        check_val("flush_ready", 64'(s_data_ready), 64'h1);
        check_val("flush_data", 64'(m_data_data), 64'h0);
        repeat (3) cycle(0, 0, 1);

        // Stall in BUSY with both sides willing: nothing moves for three cycles
        tx_q.push_back(32'h30);
        repeat (2) cycle(0, 0, 0);
        tx_q.push_back(32'h31);
        repeat (3) cycle(0, 1, 1);
        check_val("stall_hold_data", 64'(m_data_data), 64'h30);
        repeat (4) cycle(0, 0, 1);

        // Flush beats stall
        tx_q.push_back(32'h50);
        repeat (2) cycle(0, 0, 0);
        cycle(1, 1, 1);
        check_val("flush_stall_busy", 64'(s_status_busy), 64'h0);
        cycle(0, 0, 1);

        // Reset while FULL discards everything
        tx_q.push_back(32'h40);
        tx_q.push_back(32'h41);
        repeat (3) cycle(0, 0, 0);
        do_reset();
        tx_q.push_back(32'h42);
        repeat (4) cycle(0, 0, 1);

`ifdef PIPELINE_SKID_PERF_EN
        tx_q.push_back(32'h60);
        tx_q.push_back(32'h61);
        tx_q.push_back(32'h62);
        repeat (70000) cycle(0, 0, 0);
        check_val("stall_cnt_sat", 64'(s_status_stall_cnt), 64'hFFFF);
        cycle(1, 0, 0);
        check_val("stall_cnt_flush", 64'(s_status_stall_cnt), 64'h0);
        repeat (2) cycle(0, 0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
